// File: rtl/cpu_types_pkg.sv
// Shared types for the dual-core MSI system: coherence states, address field
// widths and the snoop responder FSM encoding.
package cpu_types_pkg;

    localparam int TAG_W = 26;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        M = 2'd2
    } coh_state_t;

    typedef enum logic [1:0] {
        SNP_IDLE,
        SNP_PROBE,
        SNP_WB,
        SNP_UPDATE
    } snp_state_t;

endpackage

// File: rtl/snoop_responder_if.sv
// Snoop bus plus dcache frame-array port seen by the snoop responder.
// slave = responder side, master = controller/dcache side.
interface snoop_responder_if
    import cpu_types_pkg::*;
#(
    parameter int SETS = 1 << IDX_W,
    parameter int WAYS = 2
);
    localparam int SIDX_W = $clog2(SETS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                              ccwait;
    logic                              ccinv;
    logic [31:0]                       ccsnoopaddr;
    logic                              dwait;
    logic                              snp_cctrans;
    logic [31:0]                       snp_dstore;
    logic                              snp_busy;
    logic [SIDX_W-1:0]                 snp_idx;
    logic [WAYS-1:0][TAG_W-1:0]        way_tag;
    coh_state_t [WAYS-1:0]             way_state;
    logic [WAYS-1:0][1:0][31:0]        way_word;
    logic                              upd_en;
    logic [SIDX_W-1:0]                 upd_idx;
    logic [WAY_W-1:0]                  upd_way;
    coh_state_t                        upd_state;

    modport slave (
        input  ccwait, ccinv, ccsnoopaddr, dwait, way_tag, way_state, way_word,
        output snp_cctrans, snp_dstore, snp_busy, snp_idx,
               upd_en, upd_idx, upd_way, upd_state
    );

    modport master (
        output ccwait, ccinv, ccsnoopaddr, dwait, way_tag, way_state, way_word,
        input  snp_cctrans, snp_dstore, snp_busy, snp_idx,
               upd_en, upd_idx, upd_way, upd_state
    );

endinterface

// File: rtl/snoop_probe.sv
// Zero-latency tag probe: way hit detection, Modified-hit flag and the
// writeback word mux for the snooped block offset.
module snoop_probe
    import cpu_types_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                       ccwait,
    input  logic [TAG_W-1:0]           snp_tag,
    input  logic                       snp_off,
    input  logic [WAYS-1:0][TAG_W-1:0] way_tag,
    input  coh_state_t [WAYS-1:0]      way_state,
    input  logic [WAYS-1:0][1:0][31:0] way_word,
    output logic                       hit,
    output logic [WAY_W-1:0]           hit_way,
    output coh_state_t                 hit_state,
    output logic                       cctrans,
    output logic [31:0]                dstore
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        hit     = 1'b0;
        hit_way = '0;
        // Scan downwards so the lowest-numbered matching way wins on a double hit.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_tag[w] == snp_tag && way_state[w] != I) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit_state = way_state[hit_way];
        cctrans   = ccwait & hit & (hit_state == M);
        dstore    = cctrans ? way_word[hit_way][snp_off] : 32'h0;
    end

endmodule

// File: rtl/snoop_responder.sv
// Dcache-side coherence agent: answers controller snoops, sources the
// cache-to-cache writeback and applies the MSI downgrade/invalidate.
module snoop_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    snoop_responder_if.slave  bus
);

    localparam int SIDX_W = $clog2(SETS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    snp_state_t        state_q, state_d;
    logic              inv_q, inv_d;
    logic              hit_q, hit_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [SIDX_W-1:0] idx_q, idx_d;
    coh_state_t        hstate_q, hstate_d;

    logic              probe_hit;
    logic [WAY_W-1:0]  probe_way;
    coh_state_t        probe_state;
    logic              probe_cctrans;
    logic [SIDX_W-1:0] snp_idx;
    logic              snp_err;
    logic              unused_addr_bits;

    assign snp_idx          = bus.ccsnoopaddr[3 +: SIDX_W];
    assign unused_addr_bits = ^bus.ccsnoopaddr[1:0];

    snoop_probe #(.WAYS(WAYS)) u_probe (
        .ccwait    (bus.ccwait),
        .snp_tag   (bus.ccsnoopaddr[31 -: TAG_W]),
        .snp_off   (bus.ccsnoopaddr[2]),
        .way_tag   (bus.way_tag),
        .way_state (bus.way_state),
        .way_word  (bus.way_word),
        .hit       (probe_hit),
        .hit_way   (probe_way),
        .hit_state (probe_state),
        .cctrans   (probe_cctrans),
        .dstore    (bus.snp_dstore)
    );

    assign bus.snp_cctrans = probe_cctrans;
    assign bus.snp_idx     = snp_idx;
    assign bus.snp_busy    = (state_q != SNP_IDLE);

    always_comb begin
        state_d       = state_q;
        inv_d         = inv_q;
        hit_d         = hit_q;
        way_d         = way_q;
        idx_d         = idx_q;
        hstate_d      = hstate_q;
        snp_err       = 1'b0;
        bus.upd_en    = 1'b0;
        bus.upd_idx   = '0;
        bus.upd_way   = '0;
        bus.upd_state = I;

        unique case (state_q)
            SNP_IDLE: begin
                if (bus.ccwait) state_d = SNP_PROBE;
            end
            SNP_PROBE: begin
                inv_d = inv_q | bus.ccinv;
                // The controller parks the address at zero between bus phases.
                if (bus.ccsnoopaddr != 32'h0) begin
                    hit_d    = probe_hit;
                    way_d    = probe_way;
                    idx_d    = snp_idx;
                    hstate_d = probe_state;
                end
                if (!bus.dwait && probe_cctrans && !bus.ccsnoopaddr[2]) begin
                    state_d = SNP_WB;
                end else if (!bus.ccwait) begin
                    if (inv_q && hit_q && hstate_q == S) begin
                        state_d = SNP_UPDATE;
                    end else begin
                        state_d = SNP_IDLE;
                        inv_d   = 1'b0;
                    end
                end
            end
            SNP_WB: begin
                if (!bus.dwait && bus.ccsnoopaddr[2]) begin
                    state_d = SNP_UPDATE;
                end else if (!bus.ccwait) begin
                    state_d = SNP_IDLE;
                    inv_d   = 1'b0;
                    snp_err = 1'b1;
                end
            end
            SNP_UPDATE: begin
                bus.upd_en    = 1'b1;
                bus.upd_idx   = idx_q;
                bus.upd_way   = way_q;
                bus.upd_state = inv_q ? I : S;
                state_d       = SNP_IDLE;
                inv_d         = 1'b0;
            end
            default: state_d = SNP_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= SNP_IDLE;
            inv_q    <= 1'b0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            idx_q    <= '0;
            hstate_q <= I;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q  <= state_d;
            inv_q    <= inv_d;
            hit_q    <= hit_d;
            way_q    <= way_d;
            idx_q    <= idx_d;
            hstate_q <= hstate_d;
        end
    end

    // Dropping ccwait mid-writeback breaks the controller's transfer protocol.
    snp_no_abort: assert property (@(posedge CLK) disable iff (!nRST) !snp_err);

endmodule

// File: doc/snoop_responder.md
# snoop_responder

Cache-side coherence agent for one L1 dcache in the dual-core MSI system. It answers bus snoops issued by the memory controller. It probes the dcache tag/state arrays at the snoop address, reports a Modified hit on `snp_cctrans`, and sources both block words on `dstore` during the controller's cache-to-cache writeback. It then applies the MSI downgrade M→S on a read snoop, or the invalidation M/S→I on a read-exclusive snoop. One instance sits inside each dcache, beside the cache's own miss FSM.

## Interface
- `SETS`, default 8: dcache sets; index = addr[5:3].
- `WAYS`, default 2: associativity; way select is 1 bit.
- `CLK  in  1`: clock.
- `nRST  in  1`: reset, asynchronous, active-low.
- `ccwait  in  1`: controller holds this cache for a snoop.
- `ccinv  in  1`: snoop is read-exclusive; invalidate on completion.
- `ccsnoopaddr  in  32`: snoop address; tag [31:6], index [5:3], block offset [2].
- `dwait  in  1`: low for one cycle when the RAM accepts the current writeback word.
- `snp_cctrans  out  1`: this cache holds the block in M; the dcache top ORs it into `cctrans`.
- `snp_dstore  out  32`: writeback word; the dcache top muxes it onto `dstore` while `snp_busy`.
- `snp_busy  out  1`: snoop in progress; the dcache miss FSM and CPU-side frame writes must stall.
- `snp_idx  out  3`: index presented to the frame arrays (= ccsnoopaddr[5:3]).
- `way_tag  in  WAYS×26`: tags of set `snp_idx`.
- `way_state  in  WAYS×2`: MSI state of set `snp_idx`.
- `way_word  in  WAYS×2×32`: data words of set `snp_idx`.
- `upd_en  out  1`: one-cycle state write strobe.
- `upd_idx  out  3`: set to update.
- `upd_way  out  1`: way to update.
- `upd_state  out  2`: new MSI state.

## Operation
- Combinational probe:
  - A way hits when its tag equals ccsnoopaddr[31:6] and its state is not I.
  - Both ways hitting is illegal; the way-0 match wins.
  - `snp_cctrans` = ccwait & hit & (state == M).
  - `snp_dstore` = `way_word[hitway][ccsnoopaddr[2]]` when `snp_cctrans`, else 0.
- FSM states: IDLE, PROBE, WB, UPDATE.
  - IDLE: `snp_busy` = 0. Go to PROBE when ccwait = 1.
  - PROBE:
    - `snp_busy` = 1.
    - Latch `inv_q` |= ccinv on every cycle.
    - Register hit, hit way and index whenever ccsnoopaddr is nonzero.
    - If dwait = 0, `snp_cctrans` = 1 and ccsnoopaddr[2] = 0: first word accepted, go to WB.
    - If ccwait falls, go to UPDATE if `inv_q` and the registered hit is in S; otherwise go to IDLE.
  - WB:
    - If dwait = 0 and ccsnoopaddr[2] = 1: second word accepted, go to UPDATE.
    - If ccwait falls first: protocol abort. Go to IDLE with no state change and pulse `snp_err`. `snp_err` is an internal assertion signal, not a port.
  - UPDATE:
    - `upd_en` = 1, `upd_idx` / `upd_way` = the registered values.
    - `upd_state` = I if `inv_q`, else S.
    - Next state IDLE; `inv_q` clears.
- A snoop that misses, or hits S without ccinv, ends in IDLE with no update.
- The controller serialises snoops, so a new ccwait while not IDLE cannot occur. It is treated as the continuation of the current snoop.

## Timing
- Reset values of all outputs:
  - FSM = IDLE; `snp_busy`, `upd_en`, `upd_idx`, `upd_way` all 0; `upd_state` = I; `snp_cctrans` = 0; `snp_dstore` = 0.
  - `inv_q` and the registered hit/way/index are cleared.
- Reset mid-snoop returns the FSM to IDLE immediately; no partial update is issued.
- Probe latency is zero cycles: `snp_cctrans` and `snp_dstore` are valid in the same cycle as ccsnoopaddr. This is required because the controller samples `cctrans` in its second bus cycle.
- `snp_busy` asserts the cycle after ccwait rises. The dcache must also gate on raw ccwait for that first cycle.
- The state update lands exactly one cycle after the accepting dwait-low (M case) or after ccwait falls (S-invalidate case).
- Each writeback word is held stable until its dwait-low. RAM wait states are unbounded.
- `upd_en` is never asserted in the same cycle as a CPU-side frame write; `snp_busy` guarantees this.

## Structure
- MSI enum `coh_state_t` {I = 2'd0, S = 2'd1, M = 2'd2} belongs in `cpu_types_pkg`.
- Also in `cpu_types_pkg`: the address-field widths TAG 26, IDX 3 and the snoop FSM enum.
- The probe logic (tag compare, hit, way select, word mux) is a natural sub-module, `snoop_probe`, purely combinational.
- The FSM and registers stay in `snoop_responder`.

## Test plan
- **Read snoop, M hit:** way1 tag 0x0000040, state M, words {0xDEADBEEF, 0x12345678}; snoop 0x00001008 with ccinv = 0.
  - `snp_cctrans` = 1; `snp_dstore` = 0xDEADBEEF then 0x12345678 across the two dwait-lows.
  - Then `upd_en` with idx 1, way 1, state S.
- **Read-exclusive, M hit:** same setup with ccinv = 1 for two cycles → identical writeback data, then `upd_state` = I.
- **Read-exclusive, S hit:** way0 state S → `snp_cctrans` stays 0; after ccwait falls, one `upd_en` with state I.
- **Miss:** tag mismatch in both ways, or the matching way is in I → `snp_cctrans` = 0, no `upd_en`, `snp_busy` drops one cycle after ccwait.
- **Stalled RAM:** dwait held high for 10 cycles in each writeback word → `snp_dstore` stable throughout, exactly one `upd_en`.
- **Reset mid-WB:** nRST asserted after the first word is accepted → all outputs 0 at once, no `upd_en`, the next snoop behaves normally.
